// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access stage: op codes, FSM states,
// reset constants and op classification functions.
package mem_access_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LBU  = 4'd2,
    LH   = 4'd3,
    LHU  = 4'd4,
    LW   = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG   = 5'd0;

  function automatic logic op_is_mem(input mem_op_e op);
    case (op)
      LB, LBU, LH, LHU, LW, SB, SH, SW: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    case (op)
      SB, SH, SW: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] addr);
    case (op)
      LH, LHU, SH: return addr[0];
      LW, SW:      return (addr != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane logic shared by loads and stores: lane select,
// store replication and load extraction with sign/zero extension.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane 0 is the most significant byte.
  always_comb begin
    byte_s = 8'h00;
    case (addr_i)
      2'd0:    byte_s = load_data_i[31:24];
      2'd1:    byte_s = load_data_i[23:16];
      2'd2:    byte_s = load_data_i[15:8];
      2'd3:    byte_s = load_data_i[7:0];
      default: byte_s = 8'h00;
    endcase
    if (addr_i[1]) begin
      half_s = load_data_i[15:0];
    end else begin
      half_s = load_data_i[31:16];
    end
  end

  always_comb begin
    sel_o        = 4'b0000;
    store_data_o = ZERO_WORD;
    load_data_o  = ZERO_WORD;
    case (op_i)
      LB: begin
        sel_o       = 4'b1000 >> addr_i;
        load_data_o = {{24{byte_s[7]}}, byte_s};
      end
      LBU: begin
        sel_o       = 4'b1000 >> addr_i;
        load_data_o = {24'h00_0000, byte_s};
      end
      SB: begin
        sel_o        = 4'b1000 >> addr_i;
        store_data_o = {4{store_data_i[7:0]}};
      end
      LH: begin
        sel_o       = addr_i[1] ? 4'b0011 : 4'b1100;
        load_data_o = {{16{half_s[15]}}, half_s};
      end
      LHU: begin
        sel_o       = addr_i[1] ? 4'b0011 : 4'b1100;
        load_data_o = {16'h0000, half_s};
      end
      SH: begin
        sel_o        = addr_i[1] ? 4'b0011 : 4'b1100;
        store_data_o = {2{store_data_i[15:0]}};
      end
      LW: begin
        sel_o       = 4'b1111;
        load_data_o = load_data_i;
      end
      SW: begin
        sel_o        = 4'b1111;
        store_data_o = store_data_i;
      end
      default: begin
        sel_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, runs loads/stores
// on the data-memory bus with upstream stall, flags misaligned accesses.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  mem_op_e           mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] badaddr_o,
  output logic              stall_req_o,
  mem_access_if.master      bus
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [REG_AW-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] badaddr_q, badaddr_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [REG_AW-1:0] hwd_q, hwd_d;
  logic              flush_q, flush_d;
  logic              stall_s, busy_s, flush_any_s;
  logic [3:0]        sel_s;
  logic [31:0]       st_data_s, ld_data_s;

  mem_lane_align u_lane (
    .op_i         (op_q),
    .addr_i       (addr_q[1:0]),
    .store_data_i (sdata_q),
    .load_data_i  (bus.mem_rdata),
    .sel_o        (sel_s),
    .store_data_o (st_data_s),
    .load_data_o  (ld_data_s)
  );

  assign busy_s        = (state_q == BUS);
  assign flush_any_s   = flush_q | flush_i;
  assign bus.mem_req   = busy_s;
  assign bus.mem_we    = busy_s & op_is_store(op_q);
  assign bus.mem_addr  = busy_s ? {addr_q[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
  assign bus.mem_sel   = busy_s ? sel_s : 4'b0000;
  assign bus.mem_wdata = busy_s ? st_data_s : ZERO_WORD;

  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign misalign_o  = misalign_q;
  assign badaddr_o   = badaddr_q;
  assign stall_req_o = stall_s;

  // Next-state, writeback bundle and stall decision.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    misalign_d = 1'b0;
    badaddr_d  = badaddr_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    hwd_d      = hwd_q;
    flush_d    = flush_q;
    stall_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!valid_i || flush_i) begin
          valid_d = 1'b0;
          wreg_d  = 1'b0;
        end else if (!op_is_mem(mem_op_i)) begin
          valid_d = 1'b1;
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end else if (op_misaligned(mem_op_i, mem_addr_i[1:0])) begin
          valid_d    = 1'b1;
          wreg_d     = 1'b0;
          wd_d       = wd_i;
          misalign_d = 1'b1;
          badaddr_d  = mem_addr_i;
        end else begin
          valid_d = 1'b0;
          wreg_d  = 1'b0;
          op_d    = mem_op_i;
          addr_d  = mem_addr_i;
          sdata_d = store_data_i;
          hwd_d   = wd_i;
          flush_d = 1'b0;
          stall_s = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        stall_s = ~bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = IDLE;
          valid_d = ~flush_any_s;
          wd_d    = hwd_q;
          wdata_d = ld_data_s;
          flush_d = 1'b0;
          if (op_is_store(op_q)) begin
            wreg_d = 1'b0;
          end else begin
            wreg_d = ~flush_any_s;
          end
        end else begin
          valid_d = 1'b0;
          wreg_d  = 1'b0;
          flush_d = flush_any_s;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        wreg_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      wd_q       <= NOP_REG;
      wreg_q     <= 1'b0;
      wdata_q    <= ZERO_WORD;
      misalign_q <= 1'b0;
      badaddr_q  <= {ADDR_W{1'b0}};
      op_q       <= NONE;
      addr_q     <= {ADDR_W{1'b0}};
      sdata_q    <= ZERO_WORD;
      hwd_q      <= NOP_REG;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
      badaddr_q  <= badaddr_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      hwd_q      <= hwd_d;
      flush_q    <= flush_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: ALU pass-through, loads, stores,
// misalignment, flush handling and asynchronous reset mid-transaction.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  mem_op_e     mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic        flush_i;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;
  logic [31:0] badaddr_o;
  logic        stall_req_o;

  int checks = 0;
  int errors = 0;
  int stalls;

  mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .misalign_o   (misalign_o),
    .badaddr_o    (badaddr_o),
    .stall_req_o  (stall_req_o),
    .bus          (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input mem_op_e op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] wd, input logic wr,
                       input logic [31:0] wdat, input logic fl);
    valid_i      = v;
    mem_op_i     = op;
    mem_addr_i   = addr;
    store_data_i = sdata;
    wd_i         = wd;
    wreg_i       = wr;
    wdata_i      = wdat;
    flush_i      = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_load(input string tag, input mem_op_e op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] wd, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, op, addr, 32'h0, wd, 1'b1, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = rdata;
    #1;
    chk({tag, "_req"}, {31'd0, bus_if.mem_req}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_data"}, wdata_o, exp);
    chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd1);
    chk({tag, "_wd"}, {27'd0, wd_o}, {27'd0, wd});
    @(negedge clk);
    bus_if.mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'h0;
    #12;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    chk("rst_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU pass-through
    @(negedge clk);
    drive(1'b1, NONE, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5678, 1'b0);
    #1;
    chk("alu_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("alu_wd", {27'd0, wd_o}, 32'd3);
    chk("alu_wreg", {31'd0, wreg_o}, 32'd1);
    chk("alu_valid", {31'd0, valid_o}, 32'd1);
    chk("alu_wdata", wdata_o, 32'h1234_5678);
    @(negedge clk);
    idle_in();
    @(posedge clk);
    #1;
    chk("bubble_valid", {31'd0, valid_o}, 32'd0);
    chk("bubble_wreg", {31'd0, wreg_o}, 32'd0);

    // LB 0x101 with ack on the fourth BUS cycle
    @(negedge clk);
    drive(1'b1, LB, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0);
    #1;
    stalls = 0;
    if (stall_req_o) stalls++;
    chk("lb_req_idle", {31'd0, bus_if.mem_req}, 32'd0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_in();
      bus_if.mem_ack   = (k == 3);
      bus_if.mem_rdata = 32'h11F0_3344;
      #1;
      if (stall_req_o) stalls++;
      chk("lb_req", {31'd0, bus_if.mem_req}, 32'd1);
      chk("lb_sel", {28'd0, bus_if.mem_sel}, 32'h4);
      chk("lb_addr", bus_if.mem_addr, 32'h0000_0100);
      @(posedge clk);
    end
    #1;
    chk("lb_stalls", stalls, 32'd4);
    chk("lb_req_done", {31'd0, bus_if.mem_req}, 32'd0);
    chk("lb_valid", {31'd0, valid_o}, 32'd1);
    chk("lb_wreg", {31'd0, wreg_o}, 32'd1);
    chk("lb_wd", {27'd0, wd_o}, 32'd7);
    chk("lb_wdata", wdata_o, 32'hFFFF_FFF0);
    @(negedge clk);
    bus_if.mem_ack = 1'b0;

    // SH 0x202
    @(negedge clk);
    drive(1'b1, SH, 32'h0000_0202, 32'h0000_ABCD, 5'd4, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    bus_if.mem_ack = 1'b1;
    #1;
    chk("sh_addr", bus_if.mem_addr, 32'h0000_0200);
    chk("sh_sel", {28'd0, bus_if.mem_sel}, 32'h3);
    chk("sh_data", bus_if.mem_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, bus_if.mem_we}, 32'd1);
    chk("sh_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("sh_valid", {31'd0, valid_o}, 32'd1);
    chk("sh_wreg", {31'd0, wreg_o}, 32'd0);
    chk("sh_req_done", {31'd0, bus_if.mem_req}, 32'd0);
    @(negedge clk);
    bus_if.mem_ack = 1'b0;

    // Load lane/extension variants
    do_load("lbu3", LBU, 32'h0000_0003, 32'h0000_00F0, 5'd9, 32'h0000_00F0);
    do_load("lb0", LB, 32'h0000_0010, 32'h7F00_0000, 5'd10, 32'h0000_007F);
    do_load("lh2", LH, 32'h0000_0022, 32'h0000_8001, 5'd11, 32'hFFFF_8001);
    do_load("lw4", LW, 32'h0000_0004, 32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF);

    // Misaligned LW
    @(negedge clk);
    drive(1'b1, LW, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0);
    #1;
    chk("mis_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("mis_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_badaddr", badaddr_o, 32'h0000_0103);
    chk("mis_valid", {31'd0, valid_o}, 32'd1);
    chk("mis_wreg", {31'd0, wreg_o}, 32'd0);
    @(negedge clk);
    idle_in();
    @(posedge clk);
    #1;
    chk("mis_pulse", {31'd0, misalign_o}, 32'd0);
    chk("mis_req2", {31'd0, bus_if.mem_req}, 32'd0);

    // LHU 0x0 with flush during BUS
    @(negedge clk);
    drive(1'b1, LHU, 32'h0000_0000, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    flush_i = 1'b1;
    #1;
    chk("fl_req1", {31'd0, bus_if.mem_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("fl_req2", {31'd0, bus_if.mem_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = 32'h8001_0000;
    #1;
    chk("fl_sel", {28'd0, bus_if.mem_sel}, 32'hC);
    @(posedge clk);
    #1;
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_wreg", {31'd0, wreg_o}, 32'd0);
    chk("fl_wdata", wdata_o, 32'h0000_8001);
    chk("fl_req_done", {31'd0, bus_if.mem_req}, 32'd0);

    // Ack outside BUS is ignored; flush in IDLE suppresses request and misalign
    @(negedge clk);
    drive(1'b1, LH, 32'h0000_0001, 32'h0, 5'd2, 1'b1, 32'h0, 1'b1);
    #1;
    chk("fli_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("fli_misalign", {31'd0, misalign_o}, 32'd0);
    chk("fli_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    drive(1'b1, LW, 32'h0000_0010, 32'h0, 5'd2, 1'b1, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("fli_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("fli_wreg", {31'd0, wreg_o}, 32'd0);
    @(negedge clk);
    idle_in();
    bus_if.mem_ack = 1'b0;

    // Reset mid-BUS during an SB
    @(negedge clk);
    drive(1'b1, SB, 32'h0000_0003, 32'h0000_005A, 5'd1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    #1;
    chk("sb_req", {31'd0, bus_if.mem_req}, 32'd1);
    chk("sb_sel", {28'd0, bus_if.mem_sel}, 32'h1);
    chk("sb_data", bus_if.mem_wdata, 32'h5A5A_5A5A);
    #1;
    rst = 1'b0;
    #1;
    chk("rstbus_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("rstbus_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, NONE, 32'h0, 32'h0, 5'd9, 1'b1, 32'hCAFE_F00D, 1'b0);
    @(posedge clk);
    #1;
    chk("post_wd", {27'd0, wd_o}, 32'd9);
    chk("post_wdata", wdata_o, 32'hCAFE_F00D);
    chk("post_valid", {31'd0, valid_o}, 32'd1);
    @(negedge clk);
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
